contador_parametrizado: RTL and testbench
=========================================

CONTADOR_PARAMETRIZADO -- requirements
Module: contador_parametrizado

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3: count register width in bits; legal range 1..16.
REQ-002 The block SHALL have parameter MODULO, default 8: count sequence length, values 0..MODULO-1; legal range 2..2**WIDTH.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-004 The block SHALL have port clk1, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port sclr, input, 1 bit: synchronous clear.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load of d.
REQ-008 The block SHALL have port d, input, WIDTH bits: load value.
REQ-009 The block SHALL have port en, input, 1 bit: count enable.
REQ-010 The block SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-011 The block SHALL have port Q, output, WIDTH bits: registered count value.
REQ-012 The block SHALL have port tc, output, 1 bit: combinational terminal-count flag.
REQ-013 The block SHALL have port wrap, output, 1 bit: registered one-cycle event pulse.

Function
REQ-014 Per-edge priority SHALL be: sclr, then load, then en; when none is active, Q holds.
REQ-015 sclr=1 SHALL set Q to 0 and wrap to 0, regardless of load and en.
REQ-016 load=1 with sclr=0 SHALL set Q to d when d<MODULO and to MODULO-1 when d>=MODULO, ignoring en; wrap=0.
REQ-017 en=1 and up=1 SHALL set Q to Q+1 when Q<MODULO-1.
REQ-018 en=1 and up=0 SHALL set Q to Q-1 when Q>0.
REQ-019 At a boundary with SATURATE=0 (Q=MODULO-1 counting up, or Q=0 counting down), Q SHALL become 0 (up) or MODULO-1 (down).
REQ-020 At a boundary with SATURATE=1, Q SHALL hold.
REQ-021 wrap SHALL be 1 in the cycle after an edge where en=1, sclr=0, load=0 and Q was at the boundary for the current direction, whether Q wrapped (SATURATE=0) or held (SATURATE=1); otherwise wrap SHALL be 0.
REQ-022 tc SHALL equal en AND (up ? Q==MODULO-1 : Q==0), with no registering, so tc can enable a cascaded counter's en.
REQ-023 Arithmetic SHALL be done at WIDTH bits; Q SHALL never leave 0..MODULO-1 after reset, including when MODULO=2**WIDTH.
REQ-024 A direction change SHALL take effect on the same edge with no dead cycle (e.g. Q=5 with up toggled to 0 gives Q=4 next).
REQ-025 A Q value outside 0..MODULO-1 (unreachable except by fault) SHALL be treated as a boundary, giving 0 on the next up count and MODULO-1 on the next down count.

Reset
REQ-026 clr_n=0 SHALL force Q=0 and wrap=0 immediately, independent of clk1.
REQ-027 Assertion of clr_n mid-count, including in the same cycle as load or sclr, SHALL win over all synchronous inputs.
REQ-028 After clr_n rises, the first clk1 rising edge SHALL obey REQ-014..REQ-021 normally.
REQ-029 tc SHALL reflect Q=0 during reset, i.e. tc=en AND NOT up.

Verification
REQ-030 Scenario (WIDTH=3, MODULO=8, SATURATE=0): reset, then en=1, up=1 for 10 edges -> Q follows 1..7,0,1,2; wrap=1 only in the cycle where Q=0; tc=1 while Q=7.
REQ-031 Scenario (WIDTH=3, MODULO=6): en=1, up=0 from reset -> Q follows 5,4,3,2,1,0,5; wrap pulses after each 0->5 transition; Q never reads 6 or 7.
REQ-032 Scenario (SATURATE=1, MODULO=6): count up 8 edges -> Q stops at 5; wrap=1 on each edge held at 5 with en=1; up=0 then gives Q=4.
REQ-033 Scenario (MODULO=6): load=1 with d=7 -> Q=5; load=1, en=1, d=2 -> Q=2 (load wins); sclr=1, load=1 -> Q=0.
REQ-034 Scenario: Q=4 counting, drive clr_n=0 between clock edges -> Q=0 and wrap=0 before the next edge; held low across edges with load=1 -> Q stays 0.
REQ-035 Scenario: two instances cascaded (the high counter's en driven by the low counter's tc, MODULO=8 each) -> combined value increments by 1 per clock, from 0x00 to 0x3F and then back to 0x00.

Source files
------------

// File: rtl/contador_parametrizado.sv
// Parameterised modulo up/down counter with synchronous clear/load, wrap or saturate at the
// boundaries, a combinational terminal-count flag for cascading and a registered wrap pulse.
module contador_parametrizado #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULO   = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk1,
  input  logic             clr_n,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxQ = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             q_in_range, d_in_range;
  logic             at_top, at_bottom, at_bound;

  // When MODULO fills the whole register every code is legal, so skip the compare.
  if (MODULO == (32'd1 << WIDTH)) begin : g_full_range
    assign q_in_range = 1'b1;
    assign d_in_range = 1'b1;
  end else begin : g_part_range
    localparam logic [WIDTH-1:0] ModQ = WIDTH'(MODULO);
    assign q_in_range = (cnt_q < ModQ);
    assign d_in_range = (d < ModQ);
  end

  // An out-of-range count behaves as a boundary in both directions.
  assign at_top    = (cnt_q == MaxQ) || !q_in_range;
  assign at_bottom = (cnt_q == '0) || !q_in_range;
  assign at_bound  = up ? at_top : at_bottom;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (sclr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = d_in_range ? d : MaxQ;
    end else if (en) begin
      wrap_d = at_bound;
      if (!q_in_range) begin
        cnt_d = up ? '0 : MaxQ;
      end else if (at_bound) begin
        if (!SATURATE) begin
          cnt_d = up ? '0 : MaxQ;
        end
      end else begin
        cnt_d = up ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk1 or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = cnt_q;
  assign wrap = wrap_q;
  // Unregistered so it can feed the en of a cascaded stage in the same cycle.
  assign tc   = en & (up ? (cnt_q == MaxQ) : (cnt_q == '0));

endmodule

// File: tb/tb_contador_parametrizado.sv
// Scoreboard bench for contador_parametrizado: three configurations share stimulus, plus a
// two-stage cascade.
module tb_contador_parametrizado;

  logic       clk1 = 1'b0;
  logic       clr_n;
  logic       sclr, load, en, up, cas_en;
  logic [2:0] d;
  logic [2:0] a_q, b_q, c_q, lo_q, hi_q;
  logic       a_tc, b_tc, c_tc, lo_tc, hi_tc;
  logic       a_wrap, b_wrap, c_wrap, lo_wrap, hi_wrap;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0] q;
    logic       wrap;
    logic       tc;
  } exp_t;

  exp_t sb[$];

  always #5 clk1 = ~clk1;

  contador_parametrizado #(.WIDTH(3), .MODULO(8), .SATURATE(1'b0)) u_a (
    .clk1(clk1), .clr_n(clr_n), .sclr(sclr), .load(load), .d(d), .en(en), .up(up),
    .Q(a_q), .tc(a_tc), .wrap(a_wrap)
  );
  contador_parametrizado #(.WIDTH(3), .MODULO(6), .SATURATE(1'b0)) u_b (
    .clk1(clk1), .clr_n(clr_n), .sclr(sclr), .load(load), .d(d), .en(en), .up(up),
    .Q(b_q), .tc(b_tc), .wrap(b_wrap)
  );
  contador_parametrizado #(.WIDTH(3), .MODULO(6), .SATURATE(1'b1)) u_c (
    .clk1(clk1), .clr_n(clr_n), .sclr(sclr), .load(load), .d(d), .en(en), .up(up),
    .Q(c_q), .tc(c_tc), .wrap(c_wrap)
  );
  contador_parametrizado #(.WIDTH(3), .MODULO(8), .SATURATE(1'b0)) u_lo (
    .clk1(clk1), .clr_n(clr_n), .sclr(1'b0), .load(1'b0), .d(3'd0), .en(cas_en), .up(1'b1),
    .Q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
  );
  contador_parametrizado #(.WIDTH(3), .MODULO(8), .SATURATE(1'b0)) u_hi (
    .clk1(clk1), .clr_n(clr_n), .sclr(1'b0), .load(1'b0), .d(3'd0), .en(lo_tc), .up(1'b1),
    .Q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic pulse_reset();
    clr_n  = 1'b0;
    sclr   = 1'b0;
    load   = 1'b0;
    en     = 1'b0;
    up     = 1'b1;
    d      = 3'd0;
    cas_en = 1'b0;
    tick();
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    clr_n  = 1'b0;
    sclr   = 1'b0;
    load   = 1'b0;
    d      = 3'd0;
    cas_en = 1'b0;
    en     = 1'b1;
    up     = 1'b0;
    #2;
    checks++;
    if (a_q !== 3'd0 || a_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: Q=%0d wrap=%b, required Q=0 wrap=0", a_q, a_wrap);
    end
    checks++;
    if (b_q !== 3'd0 || c_q !== 3'd0 || lo_q !== 3'd0 || hi_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_all: b=%0d c=%0d lo=%0d hi=%0d, required all 0", b_q, c_q, lo_q, hi_q);
    end
    checks++;
    if (a_tc !== 1'b1) begin
      errors++;
      $display("FAIL reset_tc_down: tc=%b, required 1", a_tc);
    end
    up = 1'b1;
    #1;
    checks++;
    if (a_tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_tc_up: tc=%b, required 0", a_tc);
    end
    load = 1'b1;
    d    = 3'd5;
    tick();
    checks++;
    if (a_q !== 3'd0 || a_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_load: Q=%0d wrap=%b, required Q=0 wrap=0", a_q, a_wrap);
    end
  endtask

  task automatic test_up_wrap();
    exp_t e;
    pulse_reset();
    en = 1'b1;
    up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      e.q    = 6'(i % 8);
      e.wrap = (i % 8 == 0);
      e.tc   = (i % 8 == 7);
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (a_q !== e.q[2:0] || a_wrap !== e.wrap || a_tc !== e.tc) begin
        errors++;
        $display("FAIL up_wrap edge %0d: Q=%0d wrap=%b tc=%b, required Q=%0d wrap=%b tc=%b",
                 i, a_q, a_wrap, a_tc, e.q, e.wrap, e.tc);
      end
    end
  endtask

  task automatic test_down_mod6();
    exp_t e;
    pulse_reset();
    en = 1'b1;
    up = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      e.q    = 6'((12 - i) % 6);
      e.wrap = (i == 1 || i == 7);
      e.tc   = (i == 6);
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (b_q !== e.q[2:0] || b_wrap !== e.wrap || b_tc !== e.tc || b_q > 3'd5) begin
        errors++;
        $display("FAIL down_mod6 edge %0d: Q=%0d wrap=%b tc=%b, required Q=%0d wrap=%b tc=%b",
                 i, b_q, b_wrap, b_tc, e.q, e.wrap, e.tc);
      end
      checks++;
      if (c_q !== 3'd0 || c_wrap !== 1'b1) begin
        errors++;
        $display("FAIL sat_hold_zero edge %0d: Q=%0d wrap=%b, required Q=0 wrap=1",
                 i, c_q, c_wrap);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    pulse_reset();
    en = 1'b1;
    up = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      e.q    = (i < 5) ? 6'(i) : 6'd5;
      e.wrap = (i >= 6);
      e.tc   = (i >= 5);
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (c_q !== e.q[2:0] || c_wrap !== e.wrap || c_tc !== e.tc) begin
        errors++;
        $display("FAIL saturate edge %0d: Q=%0d wrap=%b tc=%b, required Q=%0d wrap=%b tc=%b",
                 i, c_q, c_wrap, c_tc, e.q, e.wrap, e.tc);
      end
    end
    up = 1'b0;
    tick();
    checks++;
    if (c_q !== 3'd4 || c_wrap !== 1'b0) begin
      errors++;
      $display("FAIL saturate_turn: Q=%0d wrap=%b, required Q=4 wrap=0", c_q, c_wrap);
    end
  endtask

  typedef struct {
    logic       s, l, e, u;
    logic [2:0] dv;
    logic [2:0] qa, qb;
    logic       wb;
  } step_t;

  task automatic test_load();
    step_t tbl[5];
    exp_t  ea, eb;
    pulse_reset();
    tbl[0] = '{s: 1'b0, l: 1'b1, e: 1'b0, u: 1'b1, dv: 3'd7, qa: 3'd7, qb: 3'd5, wb: 1'b0};
    tbl[1] = '{s: 1'b0, l: 1'b1, e: 1'b1, u: 1'b1, dv: 3'd2, qa: 3'd2, qb: 3'd2, wb: 1'b0};
    tbl[2] = '{s: 1'b1, l: 1'b1, e: 1'b1, u: 1'b1, dv: 3'd3, qa: 3'd0, qb: 3'd0, wb: 1'b0};
    tbl[3] = '{s: 1'b0, l: 1'b1, e: 1'b0, u: 1'b1, dv: 3'd6, qa: 3'd6, qb: 3'd5, wb: 1'b0};
    tbl[4] = '{s: 1'b0, l: 1'b0, e: 1'b1, u: 1'b1, dv: 3'd0, qa: 3'd7, qb: 3'd0, wb: 1'b1};
    foreach (tbl[i]) begin
      sclr = tbl[i].s;
      load = tbl[i].l;
      en   = tbl[i].e;
      up   = tbl[i].u;
      d    = tbl[i].dv;
      ea   = '{q: 6'(tbl[i].qa), wrap: 1'b0, tc: 1'b0};
      eb   = '{q: 6'(tbl[i].qb), wrap: tbl[i].wb, tc: 1'b0};
      sb.push_back(ea);
      sb.push_back(eb);
      tick();
      ea = sb.pop_front();
      eb = sb.pop_front();
      checks++;
      if (a_q !== ea.q[2:0] || a_wrap !== ea.wrap || b_q !== eb.q[2:0] || b_wrap !== eb.wrap) begin
        errors++;
        $display("FAIL load step %0d: a=%0d/%b b=%0d/%b, required a=%0d/%b b=%0d/%b",
                 i, a_q, a_wrap, b_q, b_wrap, ea.q, ea.wrap, eb.q, eb.wrap);
      end
    end
    sclr = 1'b0;
    load = 1'b0;
  endtask

  task automatic test_direction();
    logic [1:0] ctl[4];
    logic [2:0] qx[4];
    exp_t       e;
    pulse_reset();
    load = 1'b1;
    d    = 3'd5;
    tick();
    load = 1'b0;
    ctl  = '{2'b10, 2'b11, 2'b10, 2'b00};
    qx   = '{3'd4, 3'd5, 3'd4, 3'd4};
    for (int i = 0; i < 4; i++) begin
      en = ctl[i][1];
      up = ctl[i][0];
      e  = '{q: 6'(qx[i]), wrap: 1'b0, tc: 1'b0};
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (a_q !== e.q[2:0] || a_wrap !== 1'b0) begin
        errors++;
        $display("FAIL direction step %0d: Q=%0d wrap=%b, required Q=%0d wrap=0",
                 i, a_q, a_wrap, e.q);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    en = 1'b1;
    up = 1'b1;
    repeat (4) tick();
    checks++;
    if (a_q !== 3'd4) begin
      errors++;
      $display("FAIL async_pre: Q=%0d, required 4", a_q);
    end
    #3;
    clr_n = 1'b0;
    #1;
    checks++;
    if (a_q !== 3'd0 || a_wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_mid: Q=%0d wrap=%b, required Q=0 wrap=0", a_q, a_wrap);
    end
    load = 1'b1;
    d    = 3'd5;
    tick();
    tick();
    checks++;
    if (a_q !== 3'd0) begin
      errors++;
      $display("FAIL async_hold_load: Q=%0d, required 0", a_q);
    end
    clr_n = 1'b1;
    load  = 1'b0;
    tick();
    checks++;
    if (a_q !== 3'd1 || a_wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_first_edge: Q=%0d wrap=%b, required Q=1 wrap=0", a_q, a_wrap);
    end
    load = 1'b1;
    d    = 3'd7;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (a_q !== 3'd0 || a_wrap !== 1'b1) begin
      errors++;
      $display("FAIL async_wrap_set: Q=%0d wrap=%b, required Q=0 wrap=1", a_q, a_wrap);
    end
    #2;
    clr_n = 1'b0;
    #1;
    checks++;
    if (a_wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_wrap_clear: wrap=%b, required 0", a_wrap);
    end
    clr_n = 1'b1;
  endtask

  task automatic test_cascade();
    exp_t e;
    pulse_reset();
    cas_en = 1'b1;
    #1;
    checks++;
    if ({hi_q, lo_q} !== 6'd0) begin
      errors++;
      $display("FAIL cascade_start: value=%0h, required 0", {hi_q, lo_q});
    end
    for (int i = 1; i <= 64; i++) begin
      e = '{q: 6'(i % 64), wrap: 1'b0, tc: 1'b0};
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if ({hi_q, lo_q} !== e.q) begin
        errors++;
        $display("FAIL cascade edge %0d: value=%0h, required %0h", i, {hi_q, lo_q}, e.q);
      end
    end
    cas_en = 1'b0;
  endtask

  task automatic test_random();
    int   m;
    logic w, t;
    exp_t e;
    pulse_reset();
    m = 0;
    for (int i = 0; i < 60; i++) begin
      sclr = ($urandom_range(0, 7) == 0);
      load = ($urandom_range(0, 5) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) == 1;
      d    = 3'($urandom_range(0, 7));
      #1;
      t = en & (up ? (m == 5) : (m == 0));
      checks++;
      if (b_tc !== t) begin
        errors++;
        $display("FAIL random_tc cycle %0d: tc=%b, required %b", i, b_tc, t);
      end
      w = 1'b0;
      if (sclr) m = 0;
      else if (load) m = (int'(d) >= 6) ? 5 : int'(d);
      else if (en && up) begin
        if (m == 5) begin m = 0; w = 1'b1; end
        else m = m + 1;
      end else if (en) begin
        if (m == 0) begin m = 5; w = 1'b1; end
        else m = m - 1;
      end
      e = '{q: 6'(m), wrap: w, tc: 1'b0};
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (b_q !== e.q[2:0] || b_wrap !== e.wrap) begin
        errors++;
        $display("FAIL random cycle %0d: Q=%0d wrap=%b, required Q=%0d wrap=%b",
                 i, b_q, b_wrap, e.q, e.wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_mod6();
    test_saturate();
    test_load();
    test_direction();
    test_async_reset();
    test_cascade();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
